// File: rtl/pulse_tx_pkg.sv
// Package for the pulse-width line encoder.
// Contents:
//   tx_state_t    frame FSM states
//   tx_timing_t   phase lengths of one configuration, in clock cycles
//   phase_cycles  length of the phase for a given state (and current bit in BIT_HI)
//   max_phase     longest phase of a configuration, used to size the phase counter
package pulse_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SYNC_LO = 3'd1,
    ST_SYNC_HI = 3'd2,
    ST_BIT_LO  = 3'd3,
    ST_BIT_HI  = 3'd4,
    ST_END_LO  = 3'd5
  } tx_state_t;

  typedef struct packed {
    int unsigned sync_lo;
    int unsigned sync_hi;
    int unsigned bit_lo;
    int unsigned zero_hi;
    int unsigned one_hi;
    int unsigned end_lo;
  } tx_timing_t;

  function automatic int unsigned phase_cycles(input tx_state_t st, input logic bit_v,
                                               input tx_timing_t t);
    int unsigned n;
    case (st)
      ST_SYNC_LO: n = t.sync_lo;
      ST_SYNC_HI: n = t.sync_hi;
      ST_BIT_LO:  n = t.bit_lo;
      ST_BIT_HI:  n = bit_v ? t.one_hi : t.zero_hi;
      ST_END_LO:  n = t.end_lo;
      default:    n = 32'd1;
    endcase
    return n;
  endfunction

  function automatic int unsigned max_phase(input tx_timing_t t);
    int unsigned m;
    m = t.sync_lo;
    if (t.sync_hi > m) m = t.sync_hi;
    if (t.bit_lo  > m) m = t.bit_lo;
    if (t.zero_hi > m) m = t.zero_hi;
    if (t.one_hi  > m) m = t.one_hi;
    if (t.end_lo  > m) m = t.end_lo;
    return m;
  endfunction

endpackage

// File: rtl/pulse_width_tx_if.sv
// Word input bus of the pulse-width transmitter (valid/ready handshake).
//   data   word to send
//   valid  data is valid
//   ready  transmitter can take a word this cycle
// master = word source, slave = transmitter.
interface pulse_width_tx_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/pulse_tx_skid.sv
// One-entry word buffer in front of the frame FSM.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   in_data_i      incoming word
//   in_valid_i     incoming word valid
//   in_ready_o     buffer empty, can take a word (registered)
//   pop_i          FSM takes a word this cycle
//   full_o         a word is held
//   out_data_o     word the FSM would take: held word, or in_data_i when empty
module pulse_tx_skid #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic                  pop_i,
  output logic                  full_o,
  output logic [DATA_WIDTH-1:0] out_data_o
);

  logic                  full_q, full_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  push, bypass;

  assign in_ready_o = !full_q;
  assign full_o     = full_q;
  assign push       = in_valid_i && !full_q;
  // Popping while empty can only happen on an accept: the word goes straight through.
  assign bypass     = pop_i && !full_q;
  assign out_data_o = full_q ? data_q : in_data_i;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (bypass) begin
      full_d = 1'b0;
    end else begin
      if (pop_i) full_d = 1'b0;
      if (push) begin
        full_d = 1'b1;
        data_d = in_data_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) full_q <= 1'b0;
    else       full_q <= full_d;
  end

  always_ff @(posedge clk_i) begin
    data_q <= data_d;
  end

endmodule

// File: rtl/pulse_width_tx.sv
// Pulse-width-encoded serial transmitter.
// A frame is: sync low, sync high, then per bit a low phase and a high phase whose
// length encodes the bit (optional even-parity bit last), then a trailing low gap.
// Ports:
//   clk_in, rst_in   clock, synchronous active-high reset
//   bus              word input (valid/ready), slave side
//   valid_out        high on every cycle of a frame
//   out              encoded line
//   frame_done_out   one-cycle pulse on the last cycle of the end gap
//   busy_out         frame in progress or word buffered
module pulse_width_tx
  import pulse_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned MSB_FIRST     = 1,
  parameter int unsigned PARITY_EN     = 0,
  parameter int unsigned SYNC_LOW_CYC  = 400,
  parameter int unsigned SYNC_HIGH_CYC = 600,
  parameter int unsigned BIT_LOW_CYC   = 200,
  parameter int unsigned ZERO_HIGH_CYC = 200,
  parameter int unsigned ONE_HIGH_CYC  = 600,
  parameter int unsigned END_LOW_CYC   = 200
) (
  input  logic             clk_in,
  input  logic             rst_in,
  pulse_width_tx_if.slave  bus,
  output logic             valid_out,
  output logic             out,
  output logic             frame_done_out,
  output logic             busy_out
);

  localparam int NBITS = int'(DATA_WIDTH + PARITY_EN);
  localparam tx_timing_t TIMING = '{
    sync_lo: SYNC_LOW_CYC,  sync_hi: SYNC_HIGH_CYC, bit_lo: BIT_LOW_CYC,
    zero_hi: ZERO_HIGH_CYC, one_hi:  ONE_HIGH_CYC,  end_lo: END_LOW_CYC
  };
  localparam int CNT_W = $clog2(max_phase(TIMING)) + 1;
  localparam int BC_W  = $clog2(DATA_WIDTH + 2);

  tx_state_t             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BC_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [NBITS-1:0]      sh_q, sh_d;
  logic                  accept, buf_full, load, phase_end;
  logic [DATA_WIDTH-1:0] word, ordered;
  logic [NBITS-1:0]      frame_bits;
  int unsigned           next_len;

  pulse_tx_skid #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
    .clk_i      (clk_in),
    .rst_i      (rst_in),
    .in_data_i  (bus.data),
    .in_valid_i (bus.valid),
    .in_ready_o (bus.ready),
    .pop_i      (load),
    .full_o     (buf_full),
    .out_data_o (word)
  );

  assign accept = bus.valid && bus.ready;

  // Shift register MSB is always the bit on the line, so reorder the word at load.
  always_comb begin
    for (int i = 0; i < int'(DATA_WIDTH); i++) begin
      ordered[i] = (MSB_FIRST != 0) ? word[i] : word[int'(DATA_WIDTH) - 1 - i];
    end
  end

  generate
    if (PARITY_EN != 0) begin : g_par
      assign frame_bits = {ordered, ^word};
    end else begin : g_nopar
      assign frame_bits = ordered;
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    bit_cnt_d = bit_cnt_q;
    load      = 1'b0;
    phase_end = (cnt_q == '0);
    case (state_q)
      ST_IDLE: begin
        if (buf_full || accept) begin
          state_d = ST_SYNC_LO;
          load    = 1'b1;
        end
      end
      ST_SYNC_LO: if (phase_end) state_d = ST_SYNC_HI;
      ST_SYNC_HI: if (phase_end) state_d = ST_BIT_LO;
      ST_BIT_LO:  if (phase_end) state_d = ST_BIT_HI;
      ST_BIT_HI: begin
        if (phase_end) begin
          sh_d      = sh_q << 1;
          bit_cnt_d = bit_cnt_q + 1'b1;
          state_d   = (bit_cnt_q == BC_W'(NBITS - 1)) ? ST_END_LO : ST_BIT_LO;
        end
      end
      ST_END_LO: begin
        if (phase_end) begin
          // A buffered word starts the next frame with no idle cycle in between.
          if (buf_full) begin
            state_d = ST_SYNC_LO;
            load    = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (load) begin
      sh_d      = frame_bits;
      bit_cnt_d = '0;
    end
  end

  // Counter is loaded with length-1 on every phase change and counts down to 0.
  assign next_len = phase_cycles(state_d, sh_d[NBITS-1], TIMING);

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q)     cnt_d = CNT_W'(next_len - 1);
    else if (state_q != ST_IDLE) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  always_ff @(posedge clk_in) begin
    sh_q <= sh_d;
  end

  assign valid_out      = (state_q != ST_IDLE);
  assign out            = (state_q == ST_SYNC_HI) || (state_q == ST_BIT_HI);
  assign frame_done_out = (state_q == ST_END_LO) && phase_end;
  assign busy_out       = valid_out || buf_full;

endmodule

// File: tb/tb_pulse_width_tx.sv
// Bench for pulse_width_tx: DATA_WIDTH=4, sync 4/6, bit low 2, zero 2, one 6, end 3.
// dut_a: MSB first, no parity.  dut_b: LSB first, even parity.
module tb_pulse_width_tx;

  localparam int DW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  logic valid_a, out_a, done_a, busy_a;
  logic valid_b, out_b, done_b, busy_b;

  pulse_width_tx_if #(.DATA_WIDTH(DW)) bus_a ();
  pulse_width_tx_if #(.DATA_WIDTH(DW)) bus_b ();

  pulse_width_tx #(
    .DATA_WIDTH(DW), .MSB_FIRST(1), .PARITY_EN(0),
    .SYNC_LOW_CYC(4), .SYNC_HIGH_CYC(6), .BIT_LOW_CYC(2),
    .ZERO_HIGH_CYC(2), .ONE_HIGH_CYC(6), .END_LOW_CYC(3)
  ) dut_a (
    .clk_in(clk), .rst_in(rst_a), .bus(bus_a),
    .valid_out(valid_a), .out(out_a), .frame_done_out(done_a), .busy_out(busy_a)
  );

  pulse_width_tx #(
    .DATA_WIDTH(DW), .MSB_FIRST(0), .PARITY_EN(1),
    .SYNC_LOW_CYC(4), .SYNC_HIGH_CYC(6), .BIT_LOW_CYC(2),
    .ZERO_HIGH_CYC(2), .ONE_HIGH_CYC(6), .END_LOW_CYC(3)
  ) dut_b (
    .clk_in(clk), .rst_in(rst_b), .bus(bus_b),
    .valid_out(valid_b), .out(out_b), .frame_done_out(done_b), .busy_out(busy_b)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic       exp_wave[$];
  logic [3:0] exp_q[$];
  logic [3:0] dec_w_q[$];
  bit         dec_ok_q[$];
  int         run_lvl_q[$];
  int         run_len_q[$];

  function automatic void add_run(input logic lvl, input int n);
    for (int i = 0; i < n; i++) exp_wave.push_back(lvl);
  endfunction

  function automatic void build_wave(input logic [3:0] w, input bit msb, input bit par);
    logic b;
    exp_wave.delete();
    add_run(1'b0, 4);
    add_run(1'b1, 6);
    for (int i = 0; i < 4; i++) begin
      b = msb ? w[3-i] : w[i];
      add_run(1'b0, 2);
      add_run(1'b1, b ? 6 : 2);
    end
    if (par) begin
      add_run(1'b0, 2);
      add_run(1'b1, (^w) ? 6 : 2);
    end
    add_run(1'b0, 3);
  endfunction

  // Decodes dut_a frames (MSB first, 4 bits) from measured run lengths.
  function automatic void decode_frame();
    logic [3:0] w;
    bit ok;
    w  = 4'd0;
    ok = 1'b1;
    if (run_len_q.size() != 11) begin
      ok = 1'b0;
    end else begin
      if (run_lvl_q[0] != 0 || run_len_q[0] != 4) ok = 1'b0;
      if (run_lvl_q[1] != 1 || run_len_q[1] != 6) ok = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (run_lvl_q[2+2*i] != 0 || run_len_q[2+2*i] != 2) ok = 1'b0;
        if (run_lvl_q[3+2*i] != 1) ok = 1'b0;
        if (run_len_q[3+2*i] == 6)      w = {w[2:0], 1'b1};
        else if (run_len_q[3+2*i] == 2) w = {w[2:0], 1'b0};
        else ok = 1'b0;
      end
      if (run_lvl_q[10] != 0 || run_len_q[10] != 3) ok = 1'b0;
    end
    dec_w_q.push_back(w);
    dec_ok_q.push_back(ok);
  endfunction

  initial begin : decoder
    int cur_len;
    int cur_lvl;
    cur_len = 0;
    cur_lvl = 0;
    forever begin
      @(negedge clk);
      if (valid_a !== 1'b1) begin
        run_lvl_q.delete();
        run_len_q.delete();
        cur_len = 0;
      end else begin
        if (cur_len > 0 && int'(out_a) == cur_lvl) begin
          cur_len++;
        end else begin
          if (cur_len > 0) begin
            run_lvl_q.push_back(cur_lvl);
            run_len_q.push_back(cur_len);
          end
          cur_lvl = int'(out_a);
          cur_len = 1;
        end
        if (done_a === 1'b1) begin
          run_lvl_q.push_back(cur_lvl);
          run_len_q.push_back(cur_len);
          cur_len = 0;
          decode_frame();
          run_lvl_q.delete();
          run_len_q.delete();
        end
      end
    end
  end

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1;
    bus_a.valid = 1'b0; bus_b.valid = 1'b0;
    bus_a.data = 4'h0;  bus_b.data = 4'h0;
    repeat (3) @(negedge clk);
    n_cmp++; if (out_a !== 1'b0)   begin n_err++; $display("FAIL reset_out_a: got %b want 0", out_a); end
    n_cmp++; if (valid_a !== 1'b0) begin n_err++; $display("FAIL reset_valid_a: got %b want 0", valid_a); end
    n_cmp++; if (bus_a.ready !== 1'b1) begin n_err++; $display("FAIL reset_ready_a: got %b want 1", bus_a.ready); end
    n_cmp++; if (busy_a !== 1'b0)  begin n_err++; $display("FAIL reset_busy_a: got %b want 0", busy_a); end
    n_cmp++; if (done_a !== 1'b0)  begin n_err++; $display("FAIL reset_done_a: got %b want 0", done_a); end
    n_cmp++; if (out_b !== 1'b0)   begin n_err++; $display("FAIL reset_out_b: got %b want 0", out_b); end
    n_cmp++; if (valid_b !== 1'b0) begin n_err++; $display("FAIL reset_valid_b: got %b want 0", valid_b); end
    n_cmp++; if (bus_b.ready !== 1'b1) begin n_err++; $display("FAIL reset_ready_b: got %b want 1", bus_b.ready); end
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy_a !== 1'b0)  begin n_err++; $display("FAIL post_reset_busy_a: got %b want 0", busy_a); end
  endtask

  task automatic test_single_word();
    int e_out, e_vld, e_done, first, len, vcount;
    logic exp_o;
    e_out = 0; e_vld = 0; e_done = 0; first = -1; vcount = 0;
    build_wave(4'b1010, 1'b1, 1'b0);
    len = exp_wave.size();
    n_cmp++; if (bus_a.ready !== 1'b1) begin n_err++; $display("FAIL single_ready: got %b want 1", bus_a.ready); end
    bus_a.data = 4'b1010; bus_a.valid = 1'b1;
    @(negedge clk);
    bus_a.valid = 1'b0; bus_a.data = 4'b0101;
    for (int i = 0; i < len + 3; i++) begin
      exp_o = (i < len) ? exp_wave[i] : 1'b0;
      if (out_a !== exp_o) begin e_out++; if (first < 0) first = i; end
      if (valid_a !== (i < len)) e_vld++;
      if (valid_a === 1'b1) vcount++;
      if (done_a !== (i == len - 1)) e_done++;
      @(negedge clk);
    end
    n_cmp++; if (e_out != 0)  begin n_err++; $display("FAIL single_wave: %0d wrong cycles (first %0d), want 0", e_out, first); end
    n_cmp++; if (e_vld != 0)  begin n_err++; $display("FAIL single_valid: %0d wrong cycles, want 0", e_vld); end
    n_cmp++; if (e_done != 0) begin n_err++; $display("FAIL single_done: %0d wrong cycles, want 0", e_done); end
    n_cmp++; if (vcount != 37) begin n_err++; $display("FAIL single_len: got %0d frame cycles want 37", vcount); end
    n_cmp++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL single_busy_after: got %b want 0", busy_a); end
  endtask

  task automatic test_lsb_parity();
    int e_out, e_vld, e_done, first, len, vcount;
    logic exp_o;
    e_out = 0; e_vld = 0; e_done = 0; first = -1; vcount = 0;
    build_wave(4'b0111, 1'b0, 1'b1);
    len = exp_wave.size();
    bus_b.data = 4'b0111; bus_b.valid = 1'b1;
    @(negedge clk);
    bus_b.valid = 1'b0; bus_b.data = 4'b1000;
    for (int i = 0; i < len + 3; i++) begin
      exp_o = (i < len) ? exp_wave[i] : 1'b0;
      if (out_b !== exp_o) begin e_out++; if (first < 0) first = i; end
      if (valid_b !== (i < len)) e_vld++;
      if (valid_b === 1'b1) vcount++;
      if (done_b !== (i == len - 1)) e_done++;
      @(negedge clk);
    end
    n_cmp++; if (e_out != 0)  begin n_err++; $display("FAIL parity_wave: %0d wrong cycles (first %0d), want 0", e_out, first); end
    n_cmp++; if (e_vld != 0)  begin n_err++; $display("FAIL parity_valid: %0d wrong cycles, want 0", e_vld); end
    n_cmp++; if (e_done != 0) begin n_err++; $display("FAIL parity_done: %0d wrong cycles, want 0", e_done); end
    n_cmp++; if (vcount != 49) begin n_err++; $display("FAIL parity_len: got %0d frame cycles want 49", vcount); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] w [3];
    int stall, gaps, t, frames;
    w[0] = 4'h3; w[1] = 4'hC; w[2] = 4'h5;
    stall = 0; gaps = 0; t = 0; frames = 0;
    exp_q.delete(); dec_w_q.delete(); dec_ok_q.delete();
    bus_a.valid = 1'b1; bus_a.data = w[0];
    exp_q.push_back(w[0]);
    @(negedge clk);
    bus_a.data = w[1];
    n_cmp++; if (bus_a.ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_second: got %b want 1", bus_a.ready); end
    exp_q.push_back(w[1]);
    @(negedge clk);
    bus_a.data = w[2];
    n_cmp++; if (bus_a.ready !== 1'b0) begin n_err++; $display("FAIL b2b_ready_third: got %b want 0", bus_a.ready); end
    while (bus_a.ready !== 1'b1 && t < 500) begin
      stall++;
      if (valid_a !== 1'b1) gaps++;
      if (done_a === 1'b1) frames++;
      @(negedge clk); t++;
    end
    exp_q.push_back(w[2]);
    n_cmp++; if (stall != 36) begin n_err++; $display("FAIL b2b_stall: got %0d cycles want 36", stall); end
    while (frames < 3 && t < 500) begin
      if (valid_a !== 1'b1) gaps++;
      if (done_a === 1'b1) frames++;
      @(negedge clk); t++;
      bus_a.valid = 1'b0; bus_a.data = 4'hF;
    end
    @(negedge clk);
    n_cmp++; if (frames != 3) begin n_err++; $display("FAIL b2b_frames: got %0d want 3", frames); end
    n_cmp++; if (gaps != 0)   begin n_err++; $display("FAIL b2b_valid_gap: got %0d low cycles want 0", gaps); end
    n_cmp++; if (dec_w_q.size() != 3) begin n_err++; $display("FAIL b2b_count: got %0d frames want 3", dec_w_q.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i < dec_w_q.size()) begin
        n_cmp++;
        if (dec_w_q[i] !== exp_q[i] || dec_ok_q[i] !== 1'b1) begin
          n_err++; $display("FAIL b2b_word%0d: got %h ok=%0d want %h ok=1", i, dec_w_q[i], dec_ok_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int vseen, t, frames;
    vseen = 0; t = 0; frames = 0;
    dec_w_q.delete(); dec_ok_q.delete();
    bus_a.valid = 1'b1; bus_a.data = 4'b1111;
    @(negedge clk);
    bus_a.data = 4'b1001;
    @(negedge clk);
    bus_a.valid = 1'b0; bus_a.data = 4'b0000;
    repeat (12) @(negedge clk);
    n_cmp++; if (out_a !== 1'b1) begin n_err++; $display("FAIL mid_in_bit_hi: got %b want 1", out_a); end
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    n_cmp++; if (out_a !== 1'b0)   begin n_err++; $display("FAIL mid_rst_out: got %b want 0", out_a); end
    n_cmp++; if (valid_a !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid: got %b want 0", valid_a); end
    n_cmp++; if (bus_a.ready !== 1'b1) begin n_err++; $display("FAIL mid_rst_ready: got %b want 1", bus_a.ready); end
    n_cmp++; if (busy_a !== 1'b0)  begin n_err++; $display("FAIL mid_rst_busy: got %b want 0", busy_a); end
    repeat (6) begin
      @(negedge clk);
      if (valid_a !== 1'b0) vseen++;
    end
    n_cmp++; if (vseen != 0) begin n_err++; $display("FAIL mid_rst_stale: got %0d active cycles want 0", vseen); end
    bus_a.valid = 1'b1; bus_a.data = 4'b0110;
    @(negedge clk);
    bus_a.valid = 1'b0; bus_a.data = 4'b1111;
    while (frames < 1 && t < 200) begin
      if (done_a === 1'b1) frames++;
      @(negedge clk); t++;
    end
    @(negedge clk);
    n_cmp++; if (dec_w_q.size() != 1) begin n_err++; $display("FAIL mid_new_count: got %0d frames want 1", dec_w_q.size()); end
    if (dec_w_q.size() > 0) begin
      n_cmp++;
      if (dec_w_q[0] !== 4'b0110 || dec_ok_q[0] !== 1'b1) begin
        n_err++; $display("FAIL mid_new_word: got %h ok=%0d want 6 ok=1", dec_w_q[0], dec_ok_q[0]);
      end
    end
  endtask

  task automatic test_random_stream();
    int t, frames, gap;
    logic [3:0] w;
    frames = 0;
    exp_q.delete(); dec_w_q.delete(); dec_ok_q.delete();
    for (int k = 0; k < 12; k++) begin
      gap = int'($urandom_range(0, 3));
      repeat (gap) begin
        bus_a.valid = 1'b0; bus_a.data = 4'($urandom_range(0, 15));
        if (done_a === 1'b1) frames++;
        @(negedge clk);
      end
      w = 4'($urandom_range(0, 15));
      bus_a.valid = 1'b1; bus_a.data = w;
      t = 0;
      while (bus_a.ready !== 1'b1 && t < 200) begin
        if (done_a === 1'b1) frames++;
        @(negedge clk); t++;
      end
      if (t >= 200) begin
        n_cmp++; n_err++; $display("FAIL rand_accept_timeout: word %0d ready=%b want 1", k, bus_a.ready);
      end else begin
        exp_q.push_back(w);
      end
      if (done_a === 1'b1) frames++;
      @(negedge clk);
    end
    bus_a.valid = 1'b0;
    t = 0;
    while (frames < exp_q.size() && t < 2000) begin
      if (done_a === 1'b1) frames++;
      @(negedge clk); t++;
    end
    @(negedge clk);
    n_cmp++;
    if (dec_w_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL rand_count: got %0d frames want %0d", dec_w_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < dec_w_q.size()) begin
        n_cmp++;
        if (dec_w_q[i] !== exp_q[i] || dec_ok_q[i] !== 1'b1) begin
          n_err++; $display("FAIL rand_word%0d: got %h ok=%0d want %h ok=1", i, dec_w_q[i], dec_ok_q[i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: time limit reached before end of tests");
    $fatal(1, "time limit");
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    bus_a.valid = 1'b0; bus_b.valid = 1'b0;
    bus_a.data = 4'h0; bus_b.data = 4'h0;
    test_reset();
    test_single_word();
    test_lsb_parity();
    test_back_to_back();
    test_reset_mid_frame();
    test_random_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
